// File: rtl/jtag_dbg_pkg.sv
// Shared constants and helpers for the system-clock side of the debug JTAG link.
package jtag_dbg_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  function automatic int unsigned nch(input int unsigned ir_w);
    return 32'd1 << ir_w;
  endfunction

  // The top bit of the scanned data register carries the action flag.
  function automatic int unsigned action_bit(input int unsigned dr_w);
    return dr_w - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_debug_cmd_sysclk_if.sv
// Command bus from the JTAG sysclk bridge toward the debug core.
interface jtag_debug_cmd_sysclk_if
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38
);
  localparam int unsigned NCH = nch(IR_W);

  logic [DR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [NCH-1:0]  take_action;
  logic [NCH-1:0]  take_no_action;

  modport master (
    output jdo, cmd_ir, cmd_valid, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  jdo, cmd_ir, cmd_valid, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/jtag_dbg_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level, emitting a registered one-cycle
// pulse on each rising edge of the synchronised level.
module jtag_dbg_sync_edge
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   edge_q, edge_d;

  // The pulse is registered so both crossings share an identical, fixed latency.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    hist_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock half of the debug JTAG link: syncs update-IR/DR, latches IR and DR,
// decodes one-hot strobes and presents a valid/ready command with overrun tracking.
module jtag_debug_cmd_sysclk
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DR_W        = 38,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [DR_W-1:0]           sr,
  input  logic [nch(IR_W)-1:0]      chan_en,
  input  logic                      overrun_clr,
  output logic                      overrun,
  output logic [CNT_W-1:0]          overrun_cnt,
  jtag_debug_cmd_sysclk_if.master   cmd_bus
);
  localparam int unsigned NCH = nch(IR_W);
  localparam int unsigned ACT = action_bit(DR_W);

  logic uir_edge, udr_edge;

  jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk_i  (clk),
    .rst_i  (reset),
    .async_i(vs_uir),
    .edge_o (uir_edge)
  );

  jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk_i  (clk),
    .rst_i  (reset),
    .async_i(vs_udr),
    .edge_o (udr_edge)
  );

  logic [IR_W-1:0]  ir_q, ir_d;
  logic [DR_W-1:0]  jdo_q, jdo_d;
  logic [IR_W-1:0]  cmd_ir_q, cmd_ir_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [NCH-1:0]   take_action_q, take_action_d;
  logic [NCH-1:0]   take_no_action_q, take_no_action_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;
  logic             chan_hit, accept, drop;

  always_comb begin
    ir_d             = uir_edge ? ir_in : ir_q;
    // Decode against the IR held before this clock, even when update-IR coincides.
    chan_hit         = udr_edge & chan_en[ir_q];
    accept           = chan_hit & (~cmd_valid_q | cmd_bus.cmd_ready);
    drop             = chan_hit & cmd_valid_q & ~cmd_bus.cmd_ready;

    jdo_d            = jdo_q;
    cmd_ir_d         = cmd_ir_q;
    cmd_valid_d      = cmd_valid_q & ~cmd_bus.cmd_ready;
    take_action_d    = '0;
    take_no_action_d = '0;
    if (accept) begin
      jdo_d                  = sr;
      cmd_ir_d               = ir_q;
      cmd_valid_d            = 1'b1;
      take_action_d[ir_q]    = sr[ACT];
      take_no_action_d[ir_q] = ~sr[ACT];
    end

    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (overrun_clr) begin
        overrun_cnt_d = CNT_W'(1);
      end else if (overrun_cnt_q != {CNT_W{1'b1}}) begin
        overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
      end
    end else if (overrun_clr) begin
      overrun_d     = 1'b0;
      overrun_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q             <= '0;
      jdo_q            <= '0;
      cmd_ir_q         <= '0;
      cmd_valid_q      <= 1'b0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overrun_q        <= 1'b0;
      overrun_cnt_q    <= '0;
    end else begin
      ir_q             <= ir_d;
      jdo_q            <= jdo_d;
      cmd_ir_q         <= cmd_ir_d;
      cmd_valid_q      <= cmd_valid_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overrun_q        <= overrun_d;
      overrun_cnt_q    <= overrun_cnt_d;
    end
  end

  assign cmd_bus.jdo            = jdo_q;
  assign cmd_bus.cmd_ir         = cmd_ir_q;
  assign cmd_bus.cmd_valid      = cmd_valid_q;
  assign cmd_bus.take_action    = take_action_q;
  assign cmd_bus.take_no_action = take_no_action_q;
  assign overrun                = overrun_q;
  assign overrun_cnt            = overrun_cnt_q;
endmodule

// File: tb/tb_jtag_debug_cmd_sysclk.sv
// Directed bench for jtag_debug_cmd_sysclk: default build plus a wider IR / deeper sync build.
module tb_jtag_debug_cmd_sysclk;
  localparam int unsigned A_S = 2;
  localparam int unsigned B_S = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_uir, a_udr, a_clr, a_ovr;
  logic [1:0]  a_ir;
  logic [37:0] a_sr;
  logic [3:0]  a_en;
  logic [7:0]  a_cnt;
  jtag_debug_cmd_sysclk_if #(.IR_W(2), .DR_W(38)) a_bus ();

  jtag_debug_cmd_sysclk #(.IR_W(2), .DR_W(38), .SYNC_STAGES(A_S), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .vs_uir     (a_uir),
    .vs_udr     (a_udr),
    .ir_in      (a_ir),
    .sr         (a_sr),
    .chan_en    (a_en),
    .overrun_clr(a_clr),
    .overrun    (a_ovr),
    .overrun_cnt(a_cnt),
    .cmd_bus    (a_bus)
  );

  logic        b_uir, b_udr, b_clr, b_ovr;
  logic [2:0]  b_ir;
  logic [15:0] b_sr;
  logic [7:0]  b_en;
  logic [7:0]  b_cnt;
  jtag_debug_cmd_sysclk_if #(.IR_W(3), .DR_W(16)) b_bus ();

  jtag_debug_cmd_sysclk #(.IR_W(3), .DR_W(16), .SYNC_STAGES(B_S), .CNT_W(8)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .vs_uir     (b_uir),
    .vs_udr     (b_udr),
    .ir_in      (b_ir),
    .sr         (b_sr),
    .chan_en    (b_en),
    .overrun_clr(b_clr),
    .overrun    (b_ovr),
    .overrun_cnt(b_cnt),
    .cmd_bus    (b_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_uir_pulse(input logic [1:0] ir);
    a_ir  = ir;
    a_uir = 1'b1;
    cyc(1);
    a_uir = 1'b0;
    cyc(A_S + 2);
  endtask

  // Returns in the cycle where the registered udr edge is being evaluated.
  task automatic a_udr_start(input logic [37:0] v);
    a_sr  = v;
    a_udr = 1'b1;
    cyc(1);
    a_udr = 1'b0;
    cyc(A_S);
  endtask

  task automatic test_reset;
    int extra;
    reset = 1'b1;
    a_udr = 1'b1;
    a_sr  = 38'h20_0000_00AA;
    cyc(3);
    n_checks++;
    if ({a_bus.jdo, a_bus.cmd_ir, a_bus.cmd_valid, a_bus.take_action, a_bus.take_no_action,
         a_ovr, a_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: jdo=%h ir=%h v=%b ta=%b tna=%b ovr=%b cnt=%0d, want all 0",
               a_bus.jdo, a_bus.cmd_ir, a_bus.cmd_valid, a_bus.take_action,
               a_bus.take_no_action, a_ovr, a_cnt);
    end
    reset = 1'b0;
    cyc(A_S + 1);
    n_checks++;
    if (a_bus.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_early_valid: got %b want 0", a_bus.cmd_valid);
    end
    cyc(1);
    n_checks++;
    if (a_bus.cmd_valid !== 1'b1 || a_bus.take_action !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_edge: valid=%b ta=%b want 1 0001", a_bus.cmd_valid, a_bus.take_action);
    end
    n_checks++;
    if (a_bus.jdo !== 38'h20_0000_00AA) begin
      n_fail++;
      $display("FAIL reset_jdo: got %h want 20000000aa", a_bus.jdo);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (a_bus.cmd_valid || (|a_bus.take_action) || (|a_bus.take_no_action)) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL reset_single_edge: %0d extra active cycles, want 0", extra);
    end
    a_udr = 1'b0;
    cyc(2);
  endtask

  task automatic test_action;
    a_uir_pulse(2'd2);
    a_udr_start(38'h20_0000_1234);
    cyc(1);
    n_checks++;
    if (a_bus.take_action !== 4'b0100 || a_bus.take_no_action !== 4'b0000) begin
      n_fail++;
      $display("FAIL action_strobe: ta=%b tna=%b want 0100 0000",
               a_bus.take_action, a_bus.take_no_action);
    end
    n_checks++;
    if (a_bus.jdo !== 38'h20_0000_1234 || a_bus.cmd_ir !== 2'd2 || a_bus.cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL action_cmd: jdo=%h ir=%0d v=%b want 2000001234 2 1",
               a_bus.jdo, a_bus.cmd_ir, a_bus.cmd_valid);
    end
    cyc(1);
    n_checks++;
    if (a_bus.take_action !== 4'b0000 || a_bus.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL action_one_cycle: ta=%b v=%b want 0000 0", a_bus.take_action, a_bus.cmd_valid);
    end
    a_udr_start(38'h00_0000_5678);
    cyc(1);
    n_checks++;
    if (a_bus.take_no_action !== 4'b0100 || a_bus.take_action !== 4'b0000) begin
      n_fail++;
      $display("FAIL no_action_strobe: ta=%b tna=%b want 0000 0100",
               a_bus.take_action, a_bus.take_no_action);
    end
    n_checks++;
    if (a_bus.jdo !== 38'h00_0000_5678) begin
      n_fail++;
      $display("FAIL no_action_jdo: got %h want 0000005678", a_bus.jdo);
    end
    cyc(1);
  endtask

  task automatic test_disable;
    a_en = 4'b1011;
    a_udr_start(38'h20_0000_9999);
    cyc(1);
    n_checks++;
    if ((a_bus.take_action | a_bus.take_no_action) !== 4'b0000 || a_bus.cmd_valid !== 1'b0 ||
        a_ovr !== 1'b0 || a_bus.jdo !== 38'h00_0000_5678) begin
      n_fail++;
      $display("FAIL disabled_chan: ta=%b tna=%b v=%b ovr=%b jdo=%h want 0 0 0 0 0000005678",
               a_bus.take_action, a_bus.take_no_action, a_bus.cmd_valid, a_ovr, a_bus.jdo);
    end
    a_en = 4'b1111;
    cyc(1);
  endtask

  task automatic test_overrun;
    a_bus.cmd_ready = 1'b0;
    a_udr_start(38'h00_1111_1111);
    cyc(1);
    n_checks++;
    if (a_bus.cmd_valid !== 1'b1 || a_bus.jdo !== 38'h00_1111_1111 || a_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_first: v=%b jdo=%h ovr=%b want 1 0011111111 0",
               a_bus.cmd_valid, a_bus.jdo, a_ovr);
    end
    a_udr_start(38'h20_2222_2222);
    cyc(1);
    n_checks++;
    if (a_bus.jdo !== 38'h00_1111_1111 || (a_bus.take_action | a_bus.take_no_action) !== 4'b0 ||
        a_bus.cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drop: jdo=%h ta|tna=%b v=%b want 0011111111 0000 1",
               a_bus.jdo, a_bus.take_action | a_bus.take_no_action, a_bus.cmd_valid);
    end
    n_checks++;
    if (a_ovr !== 1'b1 || a_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL overrun_flag: ovr=%b cnt=%0d want 1 1", a_ovr, a_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      a_udr_start(38'(i));
      cyc(1);
    end
    n_checks++;
    if (a_cnt !== 8'd255 || a_ovr !== 1'b1 || a_bus.jdo !== 38'h00_1111_1111) begin
      n_fail++;
      $display("FAIL overrun_saturate: cnt=%0d ovr=%b jdo=%h want 255 1 0011111111",
               a_cnt, a_ovr, a_bus.jdo);
    end
  endtask

  task automatic test_simultaneous;
    // Ready rises on the accept cycle of a second command.
    a_udr_start(38'h20_0000_CCCC);
    a_bus.cmd_ready = 1'b1;
    cyc(1);
    n_checks++;
    if (a_bus.cmd_valid !== 1'b1 || a_bus.jdo !== 38'h20_0000_CCCC ||
        a_bus.take_action !== 4'b0100 || a_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL accept_with_ready: v=%b jdo=%h ta=%b cnt=%0d want 1 200000cccc 0100 255",
               a_bus.cmd_valid, a_bus.jdo, a_bus.take_action, a_cnt);
    end
    cyc(1);
    n_checks++;
    if (a_bus.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_clears_valid: got %b want 0", a_bus.cmd_valid);
    end
    // Clear coinciding with an overrun event.
    a_bus.cmd_ready = 1'b0;
    a_udr_start(38'h00_0000_DDDD);
    cyc(1);
    a_udr_start(38'h00_0000_EEEE);
    a_clr = 1'b1;
    cyc(1);
    a_clr = 1'b0;
    n_checks++;
    if (a_ovr !== 1'b1 || a_cnt !== 8'd1 || a_bus.jdo !== 38'h00_0000_DDDD) begin
      n_fail++;
      $display("FAIL clr_vs_event: ovr=%b cnt=%0d jdo=%h want 1 1 000000dddd", a_ovr, a_cnt,
               a_bus.jdo);
    end
    a_clr = 1'b1;
    cyc(1);
    a_clr = 1'b0;
    n_checks++;
    if (a_ovr !== 1'b0 || a_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr=%b cnt=%0d want 0 0", a_ovr, a_cnt);
    end
    a_bus.cmd_ready = 1'b1;
    cyc(2);
    // Coincident uir/udr: current IR is 2, new IR 1 must not be used yet.
    a_ir  = 2'd1;
    a_sr  = 38'h20_0000_0F0F;
    a_uir = 1'b1;
    a_udr = 1'b1;
    cyc(1);
    a_uir = 1'b0;
    a_udr = 1'b0;
    cyc(A_S + 1);
    n_checks++;
    if (a_bus.cmd_ir !== 2'd2 || a_bus.take_action !== 4'b0100) begin
      n_fail++;
      $display("FAIL coincident_old_ir: ir=%0d ta=%b want 2 0100", a_bus.cmd_ir,
               a_bus.take_action);
    end
    cyc(2);
    a_udr_start(38'h00_0000_0001);
    cyc(1);
    n_checks++;
    if (a_bus.cmd_ir !== 2'd1 || a_bus.take_no_action !== 4'b0010) begin
      n_fail++;
      $display("FAIL coincident_new_ir: ir=%0d tna=%b want 1 0010", a_bus.cmd_ir,
               a_bus.take_no_action);
    end
    cyc(2);
  endtask

  task automatic test_param_sweep;
    logic [7:0] oh;
    logic       act;
    for (int i = 0; i < 8; i++) begin
      b_ir  = 3'(i);
      b_uir = 1'b1;
      cyc(1);
      b_uir = 1'b0;
      cyc(B_S + 2);
      act  = (i % 2 == 0);
      oh   = 8'b1 << i;
      b_sr = {act, 15'(16'h0100 + i)};
      b_udr = 1'b1;
      cyc(1);
      b_udr = 1'b0;
      cyc(B_S);
      n_checks++;
      if (b_bus.cmd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_early ir=%0d: valid=%b want 0", i, b_bus.cmd_valid);
      end
      cyc(1);
      n_checks++;
      if (b_bus.take_action !== (act ? oh : 8'h00) ||
          b_bus.take_no_action !== (act ? 8'h00 : oh) ||
          b_bus.cmd_valid !== 1'b1 || b_bus.cmd_ir !== 3'(i) ||
          b_bus.jdo !== {act, 15'(16'h0100 + i)}) begin
        n_fail++;
        $display("FAIL sweep ir=%0d: ta=%b tna=%b v=%b cir=%0d jdo=%h want ta=%b tna=%b v=1",
                 i, b_bus.take_action, b_bus.take_no_action, b_bus.cmd_valid, b_bus.cmd_ir,
                 b_bus.jdo, act ? oh : 8'h00, act ? 8'h00 : oh);
      end
      cyc(2);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_uir = 1'b0; a_udr = 1'b0; a_ir = '0; a_sr = '0; a_en = 4'b1111; a_clr = 1'b0;
    a_bus.cmd_ready = 1'b1;
    b_uir = 1'b0; b_udr = 1'b0; b_ir = '0; b_sr = '0; b_en = 8'hFF; b_clr = 1'b0;
    b_bus.cmd_ready = 1'b1;
    test_reset();
    test_action();
    test_disable();
    test_overrun();
    test_simultaneous();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_debug_cmd_sysclk.md
Name: jtag_debug_cmd_sysclk

Overview:
- System-clock half of the on-chip debug JTAG link, generalised for parametrised IR width, data-register width and synchroniser depth.
- Synchronises the TCK-domain update-IR and update-DR levels and latches the IR and the scanned data register.
- Decodes the latched IR into 2**IR_W one-hot action/no-action strobes.
- Adds a valid/ready handshake toward the debug core, per-channel enables and overrun detection, which the previous generation lacked.

Parameters:
- IR_W, 2, virtual-JTAG IR width; channel count NCH = 2**IR_W (derived localparam).
- DR_W, 38, shift-register / jdo width; bit DR_W-1 is the action flag.
- SYNC_STAGES, 2, synchroniser flops per crossing; legal range >= 2.
- CNT_W, 8, overrun counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vs_uir  in  1  update-IR level from TCK domain, asynchronous
- vs_udr  in  1  update-DR level from TCK domain, asynchronous
- ir_in  in  IR_W  IR value, quasi-static after update-IR
- sr  in  DR_W  shift-register contents, quasi-static after update-DR
- chan_en  in  NCH  per-channel enable mask
- cmd_ready  in  1  core accepts the pending command
- overrun_clr  in  1  clears overrun and overrun_cnt
- jdo  out  DR_W  captured data register
- cmd_ir  out  IR_W  IR value associated with jdo
- cmd_valid  out  1  command pending
- take_action  out  NCH  1-cycle strobe, action flag = 1
- take_no_action  out  NCH  1-cycle strobe, action flag = 0
- overrun  out  1  sticky: a command was dropped while one was pending
- overrun_cnt  out  CNT_W  saturating drop count

Behaviour:
- Reset: every output is 0, both synchroniser chains are 0, edge-history flops are 0, ir_reg is 0. A reset asserted mid-command discards the pending command.
- Synchronisation: each of vs_uir and vs_udr passes through SYNC_STAGES flops plus one history flop. edge = sync_out & ~hist.
- Rising edges only. A level held high produces exactly one edge.
- uir edge: ir_reg <= ir_in on that clock.
- udr edge: the command is evaluated against ir_reg as it was before this clock. If the uir and udr edges coincide, the udr edge uses the old ir_reg.
- Accept condition: udr edge & chan_en[ir_reg] & (~cmd_valid | cmd_ready).
- On accept, at the next clock edge:
  - jdo <= sr, cmd_ir <= ir_reg, cmd_valid <= 1.
  - take_action[ir_reg] <= sr[DR_W-1]; take_no_action[ir_reg] <= ~sr[DR_W-1].
  - All other strobe bits are 0.
- Strobes last exactly one cycle. At most one bit of take_action | take_no_action is high at a time.
- Latency: a vs_udr rise first sampled at clock edge k gives strobes and cmd_valid high after edge k+SYNC_STAGES+1.
- Disabled channel (chan_en[ir_reg] = 0): the edge is silently dropped. No strobe, no cmd_valid change, no overrun.
- Handshake:
  - cmd_valid & cmd_ready clears cmd_valid at the next edge, unless an accept occurs on the same cycle. In that case cmd_valid stays 1 and jdo/cmd_ir are updated.
  - jdo and cmd_ir are stable while cmd_valid = 1 and no accept occurs.
- Overrun: udr edge & enabled channel & cmd_valid & ~cmd_ready causes all of the following.
  - The command is dropped.
  - jdo, cmd_ir and strobes are unchanged or 0.
  - overrun <= 1.
  - overrun_cnt increments, saturating at 2**CNT_W-1.
- overrun_clr: clears overrun and overrun_cnt at the next edge. If an overrun event occurs on the same cycle, the event wins: overrun = 1, overrun_cnt = 1.
- ir_in and sr are sampled only on edge cycles. They are guaranteed stable by the JTAG protocol for at least SYNC_STAGES+2 clocks after the update.

Decomposition:
- Package jtag_dbg_pkg: ACTION_BIT = DR_W-1 helper, the NCH derivation function, and the SYNC_STAGES minimum check constant.
- Sub-module jtag_dbg_sync_edge (parameter SYNC_STAGES): synchroniser chain plus rising-edge pulse output, with synchronous active-high reset. Instantiated twice, once for vs_uir and once for vs_udr.

Test Plan:
- Reset check: reset held 3 cycles with vs_udr = 1 -> all outputs 0. After release, exactly one udr edge is processed, at SYNC_STAGES+1 cycles.
- Action decode: ir_in = 2, uir pulse, then sr = 38'h20_0000_1234 (bit 37 = 1) and udr pulse, cmd_ready = 1 -> take_action = 4'b0100 for one cycle, jdo = 38'h20_0000_1234, cmd_ir = 2, cmd_valid for 1 cycle. Repeat with bit 37 = 0 -> take_no_action = 4'b0100.
- Channel disable: chan_en = 4'b1011 and ir = 2, udr pulse -> no strobe, cmd_valid = 0, overrun = 0.
- Overrun: cmd_ready = 0, then two udr commands -> the first is held (jdo = first sr), the second is dropped, overrun = 1, overrun_cnt = 1. Next, 300 drops with CNT_W = 8 -> overrun_cnt = 255.
- Simultaneous events:
  - cmd_ready = 1 on the accept cycle of a second command -> cmd_valid stays 1 and jdo = second sr.
  - overrun_clr on the same cycle as an overrun event -> overrun_cnt = 1.
  - Coincident uir and udr edges -> the old IR is used.
- Parameter sweep: IR_W = 3, DR_W = 16, SYNC_STAGES = 3 -> 8 strobe channels, latency 4 cycles, one-hot on each IR value 0..7.
